// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

   // Scan-code prefix bytes
   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // Frame receiver states
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_t;

   // One decoded key event as presented to the scan-to-ASCII stage
   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } key_evt_t;

endpackage

// File: rtl/ps2_scan_rx_if.sv
// PS/2 line pair plus decoded key-event outputs.
// master = keyboard/host side, slave = receiver.
interface ps2_scan_rx_if;

   logic       ps2c;
   logic       ps2d;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_brk;
   logic       key_valid;
   logic       frame_err;
   logic       rx_busy;

   modport master (
      output ps2c, ps2d,
      input  key_code, key_ext, key_brk, key_valid, frame_err, rx_busy
   );

   modport slave (
      input  ps2c, ps2d,
      output key_code, key_ext, key_brk, key_valid, frame_err, rx_busy
   );

endinterface

// File: rtl/ps2_clk_filter.sv
// Two-flop synchronisers for ps2c/ps2d and a glitch filter on ps2c.
// fall is high for the single cycle in which the filtered clock drops;
// data is the synchronised ps2d, valid to sample in that same cycle.
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ps2c,
   input  logic ps2d,
   output logic fall,
   output logic data
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]    c_sync;
   logic [1:0]    d_sync;
   logic          filt;
   logic          filt_d1;
   logic [CW-1:0] cnt;

   // Synchronise both raw lines; reset to the idle-high bus level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c_sync <= 2'b11;
         d_sync <= 2'b11;
      end else begin
         c_sync <= {c_sync[0], ps2c};
         d_sync <= {d_sync[0], ps2d};
      end
   end

   // Flip the filtered level only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt    <= 1'b1;
         filt_d1 <= 1'b1;
         cnt     <= '0;
      end else begin
         filt_d1 <= filt;
         if (c_sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt <= c_sync[1];
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign fall = filt_d1 & ~filt;
   assign data = d_sync[1];

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard frame receiver with E0/F0 prefix folding.
// Emits one key event per make/break code, or a frame_err strobe on a
// parity, stop-bit or inter-edge timeout failure.
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic          clk,
   input  logic          rst_n,
   ps2_scan_rx_if.slave  bus
);

   localparam int WDW = $clog2(TIMEOUT_CYC + 1);
   // frame_err is registered, so the abort is decided one cycle early to
   // land the strobe exactly TIMEOUT_CYC cycles after the last fall event
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 2);

   logic          fall;
   logic          sdata;
   frame_state_t  state, state_nxt;
   logic [7:0]    shreg;
   logic [2:0]    bit_cnt;
   logic          par;
   logic [WDW-1:0] wdog;
   logic          rx_ok;
   logic          rx_err;
   logic          ext_pend;
   logic          brk_pend;
   key_evt_t      evt;
   logic          key_valid_q;
   logic          frame_err_q;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .ps2c  (bus.ps2c),
      .ps2d  (bus.ps2d),
      .fall  (fall),
      .data  (sdata)
   );

   // Frame state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Frame sequencing; rx_ok/rx_err are mutually exclusive completion flags
   always_comb begin
      state_nxt = state;
      rx_ok     = 1'b0;
      rx_err    = 1'b0;
      case (state)
         ST_IDLE:   if (fall && !sdata) state_nxt = ST_DATA;
         ST_DATA:   if (fall && bit_cnt == 3'd7) state_nxt = ST_PARITY;
         ST_PARITY: if (fall) state_nxt = ST_STOP;
         ST_STOP: begin
            if (fall) begin
               state_nxt = ST_IDLE;
               if (sdata && (^{shreg, par})) rx_ok  = 1'b1;
               else                          rx_err = 1'b1;
            end
         end
         default:   state_nxt = ST_IDLE;
      endcase
      // Timeout only fires in a cycle without a fall, so it never overlaps rx_ok
      if (state != ST_IDLE && !fall && wdog == WD_LAST) begin
         state_nxt = ST_IDLE;
         rx_err    = 1'b1;
      end
   end

   // Data shift register (LSB first), bit counter and parity capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
         par     <= 1'b0;
      end else if (fall) begin
         case (state)
            ST_IDLE:   bit_cnt <= '0;
            ST_DATA: begin
               shreg   <= {sdata, shreg[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
            ST_PARITY: par <= sdata;
            default: ;
         endcase
      end
   end

   // Watchdog: cycles since the last fall event while a frame is open
   always_ff @(posedge clk) begin
      if (!rst_n)                          wdog <= '0;
      else if (state == ST_IDLE || fall)   wdog <= '0;
      else                                 wdog <= wdog + WDW'(1);
   end

   // Prefix folding and key-event output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ext_pend    <= 1'b0;
         brk_pend    <= 1'b0;
         evt         <= '0;
         key_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         frame_err_q <= rx_err;
         if (rx_err) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end else if (rx_ok) begin
            if (shreg == PS2_EXT) begin
               ext_pend <= 1'b1;
            end else if (shreg == PS2_BRK) begin
               brk_pend <= 1'b1;
            end else begin
               evt         <= '{code: shreg, ext: ext_pend, brk: brk_pend};
               key_valid_q <= 1'b1;
               ext_pend    <= 1'b0;
               brk_pend    <= 1'b0;
            end
         end
      end
   end

   assign bus.key_code  = evt.code;
   assign bus.key_ext   = evt.ext;
   assign bus.key_brk   = evt.brk;
   assign bus.key_valid = key_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.rx_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: frames are bit-banged onto ps2c/ps2d
// with 12-cycle half periods; expected values are hand-computed.
module tb_ps2_scan_rx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int errors = 0;
   int kv_cnt = 0;
   int fe_cnt = 0;
   int kv_lat = 0;
   int kv0, fe0, fe_at;
   logic busy_at;

   ps2_scan_rx_if bus();

   ps2_scan_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Strobe counters; key_valid and frame_err must never coincide
   always @(negedge clk) begin
      if (bus.key_valid) kv_cnt++;
      if (bus.frame_err) fe_cnt++;
      if (bus.key_valid || bus.frame_err)
         chk("kv_fe_excl", 32'(bus.key_valid & bus.frame_err), 32'd0);
   end

   // f[0] is sent first (start bit); kv_lat records key_valid position in the low phase
   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         bus.ps2d = f[i];
         repeat (12) step();
         bus.ps2c = 1'b0;
         for (int j = 1; j <= 12; j++) begin
            step();
            if (bus.key_valid) kv_lat = j;
         end
         bus.ps2c = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
      send_bits({s, p, b, 1'b0}, 11);
      repeat (4) step();
   endtask

   initial begin
      bus.ps2c = 1'b1;
      bus.ps2d = 1'b1;
      rst_n    = 1'b0;
      repeat (4) step();
      chk("rst_code",  32'(bus.key_code),  32'h00);
      chk("rst_ext",   32'(bus.key_ext),   32'd0);
      chk("rst_brk",   32'(bus.key_brk),   32'd0);
      chk("rst_valid", 32'(bus.key_valid), 32'd0);
      chk("rst_err",   32'(bus.frame_err), 32'd0);
      chk("rst_busy",  32'(bus.rx_busy),   32'd0);
      rst_n = 1'b1;
      step();

      // Plain make code 0x1C (3 ones -> parity 0)
      kv0 = kv_cnt; kv_lat = 0;
      send_frame(8'h1C, 1'b0, 1'b1);
      chk("t1_kv_cnt", 32'(kv_cnt - kv0), 32'd1);
      chk("t1_latency", 32'(kv_lat), 32'd11);
      chk("t1_code", 32'(bus.key_code), 32'h1C);
      chk("t1_ext",  32'(bus.key_ext),  32'd0);
      chk("t1_brk",  32'(bus.key_brk),  32'd0);

      // Break: F0 (4 ones -> parity 1), 1C
      kv0 = kv_cnt;
      send_frame(8'hF0, 1'b1, 1'b1);
      chk("t2_f0_nokv", 32'(kv_cnt - kv0), 32'd0);
      send_frame(8'h1C, 1'b0, 1'b1);
      chk("t2_kv_cnt", 32'(kv_cnt - kv0), 32'd1);
      chk("t2_code", 32'(bus.key_code), 32'h1C);
      chk("t2_brk",  32'(bus.key_brk),  32'd1);
      chk("t2_ext",  32'(bus.key_ext),  32'd0);

      // Extended break: E0 (p0), F0 (p1), 6B (5 ones -> p0), then 29 (p0)
      kv0 = kv_cnt;
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b1, 1'b1);
      send_frame(8'h6B, 1'b0, 1'b1);
      chk("t3_kv_cnt", 32'(kv_cnt - kv0), 32'd1);
      chk("t3_code", 32'(bus.key_code), 32'h6B);
      chk("t3_ext",  32'(bus.key_ext),  32'd1);
      chk("t3_brk",  32'(bus.key_brk),  32'd1);
      send_frame(8'h29, 1'b0, 1'b1);
      chk("t3b_code", 32'(bus.key_code), 32'h29);
      chk("t3b_ext",  32'(bus.key_ext),  32'd0);
      chk("t3b_brk",  32'(bus.key_brk),  32'd0);

      // Bad parity, then good 0x16 (3 ones -> p0), then bad stop bit
      kv0 = kv_cnt; fe0 = fe_cnt;
      send_frame(8'h1C, 1'b1, 1'b1);
      chk("t4_par_fe",   32'(fe_cnt - fe0), 32'd1);
      chk("t4_par_nokv", 32'(kv_cnt - kv0), 32'd0);
      chk("t4_hold",     32'(bus.key_code), 32'h29);
      send_frame(8'h16, 1'b0, 1'b1);
      chk("t4_code", 32'(bus.key_code), 32'h16);
      fe0 = fe_cnt; kv0 = kv_cnt;
      send_frame(8'h1C, 1'b0, 1'b0);
      chk("t4_stop_fe",   32'(fe_cnt - fe0), 32'd1);
      chk("t4_stop_nokv", 32'(kv_cnt - kv0), 32'd0);

      // Timeout after 4 data bits; pending E0 must be dropped
      send_frame(8'hE0, 1'b0, 1'b1);
      fe0 = fe_cnt; fe_at = 0; busy_at = 1'b1;
      send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4);
      bus.ps2d = 1'b1;  // bit 3 of 0x1C
      repeat (12) step();
      bus.ps2c = 1'b0;
      for (int n = 1; n <= 130; n++) begin
         step();
         if (n == 20) bus.ps2c = 1'b1;
         if (bus.frame_err && fe_at == 0) begin
            fe_at   = n;
            busy_at = bus.rx_busy;
         end
      end
      chk("t5_fe_cycle", 32'(fe_at), 32'd110);
      chk("t5_fe_cnt",   32'(fe_cnt - fe0), 32'd1);
      chk("t5_busy",     32'(busy_at), 32'd0);
      send_frame(8'h29, 1'b0, 1'b1);
      chk("t5_code", 32'(bus.key_code), 32'h29);
      chk("t5_ext",  32'(bus.key_ext),  32'd0);

      // Reset in the middle of an E0 frame, then 0x75 (5 ones -> p0)
      kv0 = kv_cnt; fe0 = fe_cnt;
      send_bits({1'b1, 1'b0, 8'hE0, 1'b0}, 6);
      rst_n = 1'b0;
      repeat (3) step();
      chk("t6_rst_busy", 32'(bus.rx_busy), 32'd0);
      rst_n = 1'b1;
      step();
      chk("t6_no_fe", 32'(fe_cnt - fe0), 32'd0);
      chk("t6_no_kv", 32'(kv_cnt - kv0), 32'd0);
      chk("t6_code_clr", 32'(bus.key_code), 32'h00);
      send_frame(8'h75, 1'b0, 1'b1);
      chk("t6_code", 32'(bus.key_code), 32'h75);
      chk("t6_ext",  32'(bus.key_ext),  32'd0);
      chk("t6_kv",   32'(kv_cnt - kv0), 32'd1);

      // 3-cycle ps2c glitch with ps2d low must not start a frame
      bus.ps2d = 1'b0;
      repeat (4) step();
      bus.ps2c = 1'b0;
      repeat (3) step();
      bus.ps2c = 1'b1;
      repeat (20) step();
      chk("t7_glitch_busy", 32'(bus.rx_busy), 32'd0);
      bus.ps2d = 1'b1;
      repeat (4) step();
      send_frame(8'h1C, 1'b0, 1'b1);
      chk("t7_code", 32'(bus.key_code), 32'h1C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: ps2c consecutive equal samples required before the filtered level changes.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: idle clk cycles between PS/2 falling edges before an in-progress frame aborts.
REQ-003 SHALL have port clk  input  1  system clock; sole clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous to clk, active-low.
REQ-005 SHALL have port ps2c  input  1  raw PS/2 clock line, asynchronous.
REQ-006 SHALL have port ps2d  input  1  raw PS/2 data line, asynchronous.
REQ-007 SHALL have port key_code  output  8  scan code of the last completed key event, feeding the scan-to-ASCII stage.
REQ-008 SHALL have port key_ext  output  1  event was preceded by 0xE0.
REQ-009 SHALL have port key_brk  output  1  event is a release (preceded by 0xF0).
REQ-010 SHALL have port key_valid  output  1  one-cycle strobe when key_code/key_ext/key_brk are updated.
REQ-011 SHALL have port frame_err  output  1  one-cycle strobe on a parity, stop-bit or timeout failure.
REQ-012 SHALL have port rx_busy  output  1  high while the frame FSM is outside IDLE.

Function
REQ-013 SHALL pass ps2c and ps2d each through a two-flop synchroniser before any use.
REQ-014 SHALL change the filtered ps2c only after FILTER_LEN consecutive equal synchronised samples.
REQ-015 SHALL define a fall event as a 1->0 transition of the filtered ps2c, sampling synchronised ps2d in that cycle.
REQ-016 SHALL run frame FSM IDLE->DATA->PARITY->STOP->IDLE, advancing only on fall events.
REQ-017 IDLE SHALL move to DATA on a fall event with ps2d=0; a fall event with ps2d=1 SHALL be ignored.
REQ-018 DATA SHALL shift 8 bits LSB-first, using a 3-bit counter, then move to PARITY.
REQ-019 PARITY SHALL capture the bit; the frame is good when the 8 data bits plus parity have an odd number of ones.
REQ-020 STOP SHALL require ps2d=1; a good frame delivers its byte to the prefix logic in the cycle after the stop fall event.
REQ-021 A bad parity or stop bit SHALL pulse frame_err, discard the byte, clear pending prefix flags, and return to IDLE.
REQ-022 Outside IDLE, a watchdog SHALL count cycles since the last fall event; reaching TIMEOUT_CYC SHALL pulse frame_err, clear prefix flags, and return to IDLE.
REQ-023 The watchdog SHALL reset to 0 on every fall event and whenever the FSM is in IDLE.
REQ-024 Byte 0xE0 SHALL set the pending ext flag and SHALL NOT produce key_valid.
REQ-025 Byte 0xF0 SHALL set the pending brk flag and SHALL NOT produce key_valid.
REQ-026 Any other byte SHALL load key_code, load key_ext/key_brk from the pending flags, pulse key_valid for exactly one cycle, and clear both pending flags.
REQ-027 key_code, key_ext and key_brk SHALL hold their values between key_valid strobes.
REQ-028 key_valid and frame_err SHALL never assert in the same cycle.
REQ-029 Latency SHALL be one clk cycle from the stop-bit fall event to key_valid.

Reset
REQ-030 While rst_n=0 at a clk edge, the block SHALL set key_code=0x00, key_ext=0, key_brk=0, key_valid=0, frame_err=0, rx_busy=0, FSM=IDLE, clear pending flags and counters, and set the filter and synchroniser state to 1 (bus idle).
REQ-031 A reset mid-frame SHALL abandon the frame silently with no frame_err or key_valid.

Structure
REQ-032 Shared package ps2_pkg SHALL hold the frame-state enum and constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
REQ-033 The synchroniser and glitch filter SHALL be sub-module ps2_clk_filter, which outputs the fall event and the synchronised data.

Verification
REQ-034 Frame 0x1C with parity 0 -> key_valid once, key_code=0x1C, key_ext=0, key_brk=0.
REQ-035 Frames F0,1C -> a single key_valid, key_code=0x1C, key_brk=1, key_ext=0.
REQ-036 Frames E0,F0,6B -> a single key_valid, key_code=0x6B, key_ext=1, key_brk=1; a following 0x29 -> key_ext=0, key_brk=0.
REQ-037 Frame 0x1C with parity 1 -> frame_err pulse, no key_valid; a following good 0x16 -> key_code=0x16.
REQ-038 ps2c stops after 4 data bits with TIMEOUT_CYC=100 -> frame_err in the 100th cycle after the last fall event, rx_busy=0; a following good frame decodes normally.
REQ-039 rst_n=0 during the E0 frame, then frame 0x75 -> key_code=0x75, key_ext=0; a 3-cycle ps2c glitch with FILTER_LEN=8 -> no bit captured.
